// File: rtl/msk_fifo_pkg.sv
// ---------------------------------------------------------------------------
// msk_fifo_pkg
// Shared definitions for the masked-share FIFO slice.
//   ptr_width   : width of the public read/write pointers, max(1, clog2(DEPTH))
//   level_width : width of the public fill level, clog2(DEPTH+1)
//   rnd_width   : width of the refresh randomness bus; a d=1 build keeps a
//                 one-bit bus that is never read
//   share_idx   : flat bit position of share j of bit i (j*count+i)
//   fifo_op_e   : handshake outcome of one cycle, {write, read}
// Optional build macro: MSK_FIFO_REFRESH_EN (share refresh on write).
// ---------------------------------------------------------------------------
package msk_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int rnd_width(input int d, input int count);
        return (d > 1) ? count * (d - 1) : 1;
    endfunction

    function automatic int share_idx(input int j, input int i, input int count);
        return j * count + i;
    endfunction

endpackage

// File: rtl/msk_share_fifo_if.sv
// ---------------------------------------------------------------------------
// msk_share_fifo_if
// Bundles both handshake sides of the masked-share FIFO plus its public level.
//   in_valid / in_ready / in    : producer side, in is count*d bits,
//                                 bit j*count+i = share j of bit i
//   out_valid / out_ready / out : consumer side, same layout as in
//   level                       : number of stored entries
//   rnd                         : fresh randomness (MSK_FIFO_REFRESH_EN only)
// Modports:
//   slave  : the FIFO itself
//   master : the environment (producer + consumer)
// Optional build macro: MSK_FIFO_REFRESH_EN adds rnd.
// ---------------------------------------------------------------------------
interface msk_share_fifo_if
    import msk_fifo_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int DEPTH = 4
);

    localparam int W  = count * d;
    localparam int LW = level_width(DEPTH);
    localparam int RW = rnd_width(d, count);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic [LW-1:0] level;
`ifdef MSK_FIFO_REFRESH_EN
    logic [RW-1:0] rnd;

    modport slave (
        input  in_valid, in, out_ready, rnd,
        output in_ready, out_valid, out, level
    );

    modport master (
        output in_valid, in, out_ready, rnd,
        input  in_ready, out_valid, out, level
    );
`else
    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, level
    );

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, level
    );
`endif

endinterface

// File: rtl/msk_reg_en.sv
// ---------------------------------------------------------------------------
// msk_reg_en
// One FIFO entry: a WIDTH-bit share register with write enable.
// The register carries keep/preserve attributes so synthesis can neither
// merge nor re-time bits belonging to different shares. It has no reset:
// contents are don't-care until first written.
//   clk     : clock
//   en      : load data_in on this edge
//   data_in : sharing to store
//   data_q  : stored sharing
// ---------------------------------------------------------------------------
module msk_reg_en
    import msk_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_q
);

    (* keep = "true", preserve = "true" *) logic [WIDTH-1:0] share_r;

    // Entry storage: load on enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (en) begin
            share_r <= data_in;
        end else begin
            share_r <= share_r;
        end
    end

    assign data_q = share_r;

endmodule

// File: rtl/msk_share_fifo.sv
// ---------------------------------------------------------------------------
// msk_share_fifo
// Elastic valid/ready buffer for masked sharings. Shares are stored and
// selected by the public read pointer only; they are never combined, except
// by the optional refresh applied on the write path. Minimum latency is one
// cycle (no bypass), the same as a plain share register.
//   clk  : clock
//   rst  : synchronous active-high reset
//   fifo : msk_share_fifo_if.slave -- in_valid/in_ready/in,
//          out_valid/out_ready/out, level, and rnd when refresh is built
// Parameters: d (shares per bit), count (bits per entry), DEPTH (entries,
// any value >= 1).
// Optional build macro: MSK_FIFO_REFRESH_EN re-masks every sharing with rnd
// as it is written; without it the sharing is stored verbatim.
// ---------------------------------------------------------------------------
module msk_share_fifo
    import msk_fifo_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    msk_share_fifo_if.slave  fifo
);

    localparam int W  = count * d;
    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);

    // Pointer / level state
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          in_ready_r;
    logic          out_valid_r;

    // Next-state and handshake decode
    logic          wr_s;
    logic          rd_s;
    fifo_op_e      op_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] level_nxt_s;

    // Write data path and storage
    logic [W-1:0]       store_s;
    logic [DEPTH-1:0]   wr_en_s;
    logic [W-1:0]       storage_s [DEPTH];

    // Handshakes only look at registered flags, so in_ready never depends
    // on out_ready and there is no combinational path through the FIFO.
    assign wr_s = fifo.in_valid  & in_ready_r;
    assign rd_s = out_valid_r    & fifo.out_ready;

`ifdef MSK_FIFO_REFRESH_EN
    logic [count-1:0] mask_acc_s;

    // Refresh: re-mask shares 0..d-2 with rnd and fold the XOR of the same
    // rnd bits into share d-1, so the unshared value is preserved. This is
    // the only place where bits of different share indices meet.
    always_comb begin
        store_s    = fifo.in;
        mask_acc_s = {count{1'b0}};
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < d - 1; j++) begin
                store_s[share_idx(j, i, count)] =
                    fifo.in[share_idx(j, i, count)] ^ fifo.rnd[share_idx(j, i, count)];
                mask_acc_s[i] = mask_acc_s[i] ^ fifo.rnd[share_idx(j, i, count)];
            end
            store_s[share_idx(d - 1, i, count)] =
                fifo.in[share_idx(d - 1, i, count)] ^ mask_acc_s[i];
        end
    end
`else
    // Plain build: the sharing is stored exactly as presented.
    always_comb begin
        store_s = fifo.in;
    end
`endif

    // Level and pointer next-state from the cycle's handshake outcome.
    always_comb begin
        op_s         = fifo_op_e'({wr_s, rd_s});
        level_nxt_s  = level_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;

        case (op_s)
            OP_WRITE: level_nxt_s = level_r + LVL_ONE;
            OP_READ:  level_nxt_s = level_r - LVL_ONE;
            OP_BOTH:  level_nxt_s = level_r;
            OP_IDLE:  level_nxt_s = level_r;
            default:  level_nxt_s = level_r;
        endcase

        // Pointers wrap explicitly so non-power-of-two depths work.
        if (wr_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rd_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Control state; in_ready/out_valid are registered copies of the
    // full/empty decode of the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LVL_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            in_ready_r  <= (level_nxt_s != LVL_FULL);
            out_valid_r <= (level_nxt_s != LVL_ZERO);
        end
    end

    // One share register per entry, enabled only at the write pointer.
    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign wr_en_s[k] = wr_s & (wr_ptr_r == PW'(k));

        msk_reg_en #(
            .WIDTH (W)
        ) u_share_reg (
            .clk     (clk),
            .en      (wr_en_s[k]),
            .data_in (store_s),
            .data_q  (storage_s[k])
        );
    end

    // Selection uses the public read pointer only; out is not gated by
    // out_valid and is stale when the FIFO is empty.
    assign fifo.out       = storage_s[rd_ptr_r];
    assign fifo.in_ready  = in_ready_r;
    assign fifo.out_valid = out_valid_r;
    assign fifo.level     = level_r;

endmodule
